// File: rtl/mycpu_pkg.sv
// Shared definitions for the MEM stage: control-word bit positions,
// access size codes and the access FSM states.
package mycpu_pkg;

    localparam int C8_SIGN    = 0;
    localparam int C8_SIZE_LO = 1;
    localparam int C8_STORE   = 4;
    localparam int C8_LOAD    = 5;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_WL = 3'b011,
        SZ_WR = 3'b100
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mycpu_mem_align.sv
// Store lane steering (byte enables + data) and load data merge,
// including the unaligned LWL/LWR/SWL/SWR forms.
module mycpu_mem_align
    import mycpu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        sign_ext,
    input  logic [31:0] rt,
    input  logic [31:0] rdata,
    output logic [3:0]  st_wen,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data
);

    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_shift = rdata >> {addr_lo, 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        st_wen   = 4'b1111;
        st_wdata = rt;
        ld_data  = rdata;

        case (size)
            SZ_B: begin
                st_wen   = 4'b0001 << addr_lo;
                st_wdata = {4{rt[7:0]}};
                ld_data  = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            end
            SZ_H: begin
                st_wen   = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rt[15:0]}};
                ld_data  = {{16{sign_ext & rd_half[15]}}, rd_half};
            end
            // ~addr_lo is 3-a: the left part covers bytes a..0 of the word
            SZ_WL: begin
                st_wen   = 4'b1111 >> ~addr_lo;
                st_wdata = rt >> {~addr_lo, 3'b000};
                case (addr_lo)
                    2'd0:    ld_data = {rdata[7:0],  rt[23:0]};
                    2'd1:    ld_data = {rdata[15:0], rt[15:0]};
                    2'd2:    ld_data = {rdata[23:0], rt[7:0]};
                    default: ld_data = rdata;
                endcase
            end
            SZ_WR: begin
                st_wen   = 4'b1111 << addr_lo;
                st_wdata = rt << {addr_lo, 3'b000};
                case (addr_lo)
                    2'd0:    ld_data = rdata;
                    2'd1:    ld_data = {rt[31:24], rdata[31:8]};
                    2'd2:    ld_data = {rt[31:16], rdata[31:16]};
                    default: ld_data = {rt[31:8],  rdata[31:24]};
                endcase
            end
            default: begin
                st_wen   = 4'b1111;
                st_wdata = rt;
                ld_data  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mycpu_mem_stage.sv
// MEM stage of the 5-stage pipeline: drives the synchronous data SRAM,
// waits MEM_LAT cycles for load data and hands a merged result to WB.
module mycpu_mem_stage
    import mycpu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        mem_allowin,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [5:0]  ex_c8,
    input  logic [4:0]  ex_target_reg,
    input  logic        ex_wen,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        wb_valid,
    input  logic        wb_allowin,
    output logic [4:0]  wb_target_reg,
    output logic        wb_wen,
    output logic [31:0] wb_wdata,
    output logic [5:0]  mem_fwd_treg,
    output logic [31:0] mem_fwd_data
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    logic        valid;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [5:0]  c8;
    logic [4:0]  target;
    logic        wen;

    mem_state_e  state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] ld_q;
    logic        ld_cap;
    logic        ready_go;

    logic        is_load, is_store;
    logic [3:0]  al_wen;
    logic [31:0] al_wdata, al_ld;

    assign is_load  = c8[C8_LOAD];
    assign is_store = c8[C8_STORE];

    mycpu_mem_align u_align (
        .addr_lo  (result[1:0]),
        .size     (size_e'(c8[C8_SIZE_LO +: 3])),
        .sign_ext (c8[C8_SIGN]),
        .rt       (store_data),
        .rdata    (data_sram_rdata),
        .st_wen   (al_wen),
        .st_wdata (al_wdata),
        .ld_data  (al_ld)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_go  = 1'b0;
        ld_cap    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid) begin
                    if (is_load) begin
                        cnt_nxt   = 3'd1;
                        state_nxt = ST_WAIT;
                    end else begin
                        ready_go = 1'b1;
                        // a stalled store must not write the SRAM a second time
                        if (is_store && !wb_allowin)
                            state_nxt = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == LAT) begin
                    ld_cap    = 1'b1;
                    cnt_nxt   = 3'd0;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            ST_DONE: begin
                ready_go = 1'b1;
                if (wb_allowin)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mem_allowin = !valid || (ready_go && wb_allowin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= 1'b0;
            result     <= 32'd0;
            store_data <= 32'd0;
            c8         <= 6'd0;
            target     <= 5'd0;
            wen        <= 1'b0;
        end else if (ex_valid && mem_allowin) begin
            valid      <= 1'b1;
            result     <= ex_result;
            store_data <= ex_store_data;
            c8         <= ex_c8;
            target     <= ex_target_reg;
            wen        <= ex_wen;
        end else if (ready_go && wb_allowin) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ld_q <= 32'd0;
        else if (ld_cap)
            ld_q <= al_ld;
    end

    assign data_sram_en    = valid && (state == ST_IDLE) && (is_load || is_store);
    assign data_sram_wen   = (data_sram_en && is_store) ? al_wen : 4'b0000;
    assign data_sram_addr  = {result[31:2], 2'b00};
    assign data_sram_wdata = al_wdata;

    assign wb_valid      = valid && ready_go;
    assign wb_target_reg = target;
    assign wb_wen        = wen;
    assign wb_wdata      = (is_load && state == ST_DONE) ? ld_q : result;

    assign mem_fwd_treg = {valid && is_load && (state != ST_DONE),
                           (valid && wen) ? target : 5'd0};
    assign mem_fwd_data = wb_wdata;

endmodule

// File: tb/tb_mycpu_mem_stage.sv
// Directed checks of mycpu_mem_stage with MEM_LAT=1 (index 0) and
// MEM_LAT=3 (index 1) instances sharing stimulus buses.
module tb_mycpu_mem_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  ex_valid;
    logic [31:0] ex_result, ex_store_data;
    logic [5:0]  ex_c8;
    logic [4:0]  ex_target_reg;
    logic        ex_wen, wb_allowin;

    logic        mem_allowin [2];
    logic        sram_en     [2];
    logic [3:0]  sram_wen    [2];
    logic [31:0] sram_addr   [2];
    logic [31:0] sram_wdata  [2];
    logic [31:0] sram_rdata  [2];
    logic        wb_valid    [2];
    logic [4:0]  wb_target   [2];
    logic        wb_wen      [2];
    logic [31:0] wb_wdata    [2];
    logic [5:0]  fwd_treg    [2];
    logic [31:0] fwd_data    [2];

    mycpu_mem_stage #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid[0]), .mem_allowin(mem_allowin[0]),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_c8(ex_c8),
        .ex_target_reg(ex_target_reg), .ex_wen(ex_wen),
        .data_sram_en(sram_en[0]), .data_sram_wen(sram_wen[0]),
        .data_sram_addr(sram_addr[0]), .data_sram_wdata(sram_wdata[0]),
        .data_sram_rdata(sram_rdata[0]), .wb_valid(wb_valid[0]), .wb_allowin(wb_allowin),
        .wb_target_reg(wb_target[0]), .wb_wen(wb_wen[0]), .wb_wdata(wb_wdata[0]),
        .mem_fwd_treg(fwd_treg[0]), .mem_fwd_data(fwd_data[0])
    );

    mycpu_mem_stage #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid[1]), .mem_allowin(mem_allowin[1]),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_c8(ex_c8),
        .ex_target_reg(ex_target_reg), .ex_wen(ex_wen),
        .data_sram_en(sram_en[1]), .data_sram_wen(sram_wen[1]),
        .data_sram_addr(sram_addr[1]), .data_sram_wdata(sram_wdata[1]),
        .data_sram_rdata(sram_rdata[1]), .wb_valid(wb_valid[1]), .wb_allowin(wb_allowin),
        .wb_target_reg(wb_target[1]), .wb_wen(wb_wen[1]), .wb_wdata(wb_wdata[1]),
        .mem_fwd_treg(fwd_treg[1]), .mem_fwd_data(fwd_data[1])
    );

    // SRAM model: returns mem_word exactly MEM_LAT cycles after en, junk otherwise
    logic [31:0] mem_word = 32'd0;
    logic [3:0]  pipe1 = 4'd0;
    logic [3:0]  pipe3 = 4'd0;
    always @(posedge clk) begin
        pipe1 <= {pipe1[2:0], sram_en[0]};
        pipe3 <= {pipe3[2:0], sram_en[1]};
    end
    assign sram_rdata[0] = pipe1[0] ? mem_word : 32'hDEADBEEF;
    assign sram_rdata[1] = pipe3[2] ? mem_word : 32'hDEADBEEF;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input int d, input logic [31:0] res, input logic [31:0] rt,
                         input logic [5:0] c8, input logic [4:0] tgt, input logic w);
        ex_result     = res;
        ex_store_data = rt;
        ex_c8         = c8;
        ex_target_reg = tgt;
        ex_wen        = w;
        ex_valid[d]   = 1'b1;
        @(posedge clk);
        #1 ex_valid[d] = 1'b0;
    endtask

    task automatic load1(input string tag, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [5:0] c8, input logic [31:0] mw, input logic [31:0] exp);
        mem_word = mw;
        issue(0, addr, rt, c8, 5'd3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_valid"}, wb_valid[0], 1'b1);
        check({tag, "_data"}, wb_wdata[0], exp);
        @(negedge clk);
    endtask

    task automatic store1(input string tag, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [5:0] c8, input logic [3:0] wen_e, input logic [31:0] wd_e);
        issue(0, addr, rt, c8, 5'd0, 1'b0);
        @(negedge clk);
        check({tag, "_en"}, sram_en[0], 1'b1);
        check({tag, "_wen"}, sram_wen[0], wen_e);
        check({tag, "_wdata"}, sram_wdata[0], wd_e);
        check({tag, "_addr"}, sram_addr[0], {addr[31:2], 2'b00});
        check({tag, "_wbv"}, wb_valid[0], 1'b1);
        @(negedge clk);
        check({tag, "_done"}, sram_en[0], 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int pend, en_cnt, vcnt, writes;
        ex_valid = 2'b00; ex_result = '0; ex_store_data = '0; ex_c8 = '0;
        ex_target_reg = '0; ex_wen = 1'b0; wb_allowin = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_allowin", mem_allowin[d], 1'b1);
            check("rst_en", sram_en[d], 1'b0);
            check("rst_wen", sram_wen[d], 4'b0);
            check("rst_wbv", wb_valid[d], 1'b0);
            check("rst_treg", fwd_treg[d], 6'd0);
            check("rst_wdata", wb_wdata[d], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        store1("sb", 32'h1003, 32'h000000AB, 6'b010000, 4'b1000, 32'hABABABAB);
        store1("swl", 32'h0001, 32'h11223344, 6'b010110, 4'b0011, 32'h00001122);
        store1("swr", 32'h0002, 32'h11223344, 6'b011000, 4'b1100, 32'h33440000);
        store1("sh", 32'h0006, 32'h0000BEEF, 6'b010010, 4'b1100, 32'hBEEFBEEF);

        // LB timing walk-through at MEM_LAT=1
        mem_word = 32'h0000F000;
        issue(0, 32'h2001, 32'd0, 6'b100001, 5'd5, 1'b1);
        @(negedge clk);
        check("lb_c0_en", sram_en[0], 1'b1);
        check("lb_c0_wen", sram_wen[0], 4'b0);
        check("lb_c0_addr", sram_addr[0], 32'h2000);
        check("lb_c0_treg", fwd_treg[0], 6'h25);
        check("lb_c0_wbv", wb_valid[0], 1'b0);
        @(negedge clk);
        check("lb_c1_wbv", wb_valid[0], 1'b0);
        check("lb_c1_allowin", mem_allowin[0], 1'b0);
        @(negedge clk);
        check("lb_c2_wbv", wb_valid[0], 1'b1);
        check("lb_c2_data", wb_wdata[0], 32'hFFFFFFF0);
        check("lb_c2_treg", fwd_treg[0], 6'h05);
        check("lb_c2_fwd", fwd_data[0], 32'hFFFFFFF0);
        @(negedge clk);
        check("lb_after_wbv", wb_valid[0], 1'b0);

        load1("lbu", 32'h2001, 32'd0, 6'b100000, 32'h0000F000, 32'h000000F0);
        load1("lwl", 32'h0002, 32'h11223344, 6'b100110, 32'hAABBCCDD, 32'hBBCCDD44);
        load1("lwr", 32'h0001, 32'h11223344, 6'b101000, 32'hAABBCCDD, 32'h11AABBCC);
        load1("lh", 32'h0002, 32'd0, 6'b100011, 32'h8001_1234, 32'hFFFF8001);
        load1("lw", 32'h0003, 32'd0, 6'b100100, 32'h12345678, 32'h12345678);

        // back-to-back ALU results, no bubble
        ex_result = 32'hA0A0A0A0; ex_c8 = 6'd0; ex_target_reg = 5'd7; ex_wen = 1'b1;
        ex_valid[0] = 1'b1;
        @(posedge clk);
        #1 ex_result = 32'hB1B1B1B1; ex_target_reg = 5'd8;
        @(negedge clk);
        check("b2b_a_data", wb_wdata[0], 32'hA0A0A0A0);
        check("b2b_a_treg", fwd_treg[0], 6'h07);
        check("b2b_a_allowin", mem_allowin[0], 1'b1);
        @(posedge clk);
        #1 ex_valid[0] = 1'b0;
        @(negedge clk);
        check("b2b_b_wbv", wb_valid[0], 1'b1);
        check("b2b_b_data", wb_wdata[0], 32'hB1B1B1B1);
        check("b2b_b_tgt", wb_target[0], 5'd8);
        @(negedge clk);
        check("b2b_idle", wb_valid[0], 1'b0);

        // MEM_LAT=3 load with WB stalled for two result cycles
        wb_allowin = 1'b0;
        mem_word = 32'hCAFEF00D;
        issue(1, 32'h40, 32'd0, 6'b100100, 5'd9, 1'b1);
        pend = 0; en_cnt = 0; vcnt = 0; writes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fwd_treg[1][5]) pend++;
            if (sram_en[1]) en_cnt++;
            if (wb_valid[1]) begin
                vcnt++;
                check("lat3_hold", wb_wdata[1], 32'hCAFEF00D);
                if (vcnt == 2) wb_allowin = 1'b1;
                if (wb_allowin) writes++;
            end
        end
        wb_allowin = 1'b1;
        check("lat3_pending", pend, 4);
        check("lat3_en_once", en_cnt, 1);
        check("lat3_vcycles", vcnt, 2);
        check("lat3_writes", writes, 1);

        // reset while the read is outstanding
        issue(1, 32'h80, 32'd0, 6'b100100, 5'd9, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("rstw_pending", fwd_treg[1][5], 1'b1);
        rst = 1'b1;
        #1;
        check("rstw_wbv", wb_valid[1], 1'b0);
        check("rstw_en", sram_en[1], 1'b0);
        check("rstw_treg", fwd_treg[1], 6'd0);
        check("rstw_allowin", mem_allowin[1], 1'b1);
        @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_valid[1]) vcnt++;
        end
        check("rstw_no_wb", vcnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
